// File: rtl/ram_side_controller.sv
// RAM-side engine: drains cache-line requests from the command FIFO and runs
// them against a 16-bit synchronous RAM, returning read lines as four beats.
module ram_side_controller #(
    parameter int ADDR_SIZE = 13,
    parameter int DATA_W    = 16,
    parameter int BEATS     = 4
) (
    input  logic                 clk,
    input  logic                 not_reset,
    input  logic                 cmd_empty,
    input  logic [DATA_W-1:0]    cmd_rdata,
    output logic                 cmd_read,
    input  logic                 rsp_full,
    output logic                 rsp_write,
    output logic [DATA_W-1:0]    rsp_wdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE+1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        RD_REQ  = 3'd2,
        RD_CAP  = 3'd3,
        RD_PUSH = 3'd4
    } state_t;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t               state;
    logic [1:0]           beat;
    logic [1:0]           beat_next;
    logic                 rnw;
    logic [ADDR_SIZE-1:0] line_addr;
    logic                 header_unused;

    assign beat_next = beat + 2'd1;

    // Header bits between the address field and rnw carry no meaning.
    assign header_unused = ^{rnw, cmd_rdata[DATA_W-2:ADDR_SIZE]};

    assign cmd_read  = not_reset && ((state == IDLE) || (state == WR_DATA)) && !cmd_empty;
    assign rsp_write = not_reset && (state == RD_PUSH) && !rsp_full;
    assign busy      = (state != IDLE);

    // Request sequencer. The read strobe is issued on entry to RD_REQ so the
    // synchronous RAM data is ready for capture at the end of RD_CAP.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state     <= IDLE;
            beat      <= 2'd0;
            rnw       <= 1'b0;
            line_addr <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cmd_empty) begin
                        rnw       <= cmd_rdata[DATA_W-1];
                        line_addr <= cmd_rdata[ADDR_SIZE-1:0];
                        beat      <= 2'd0;
                        if (cmd_rdata[DATA_W-1]) begin
                            mem_en   <= 1'b1;
                            mem_addr <= {cmd_rdata[ADDR_SIZE-1:0], 2'd0};
                            state    <= RD_REQ;
                        end else begin
                            state <= WR_DATA;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WR_DATA: begin
                    if (!cmd_empty) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {line_addr, beat};
                        mem_wdata <= cmd_rdata;
                        beat      <= beat_next;
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                        end else begin
                            state <= WR_DATA;
                        end
                    end else begin
                        state <= WR_DATA;
                    end
                end
                RD_REQ: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    rsp_wdata <= mem_rdata;
                    state     <= RD_PUSH;
                end
                RD_PUSH: begin
                    if (!rsp_full) begin
                        beat <= beat_next;
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= {line_addr, beat_next};
                            state    <= RD_REQ;
                        end
                    end else begin
                        state <= RD_PUSH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
